// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine.
// Angle table, gain constants and pi scaling helpers.
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // atan table entries are Q3.61, truncated to FRAC on use
  localparam int ATAN_FB = 61;
  localparam int ATAN_N  = 64;

  localparam logic [63:0] PI_Q61 = 64'h6487ED5110B4611A;
  localparam logic [63:0] K_Q30  = 64'd652032874;
  localparam logic [63:0] AN_Q30 = 64'd1768195364;

  // atan(2^-i) in Q3.61 via its odd power series, 8 guard bits
  function automatic logic [63:0] atan_q61(input int i);
    logic [127:0] acc;
    logic [127:0] t;
    int sh;
    if (i == 0) return 64'h1921FB54442D1846;
    acc = '0;
    for (int k = 0; k < 36; k++) begin
      sh = ATAN_FB + 8 - i * (2 * k + 1);
      if (sh >= 0) begin
        t = (128'd1 << sh) / 128'(2 * k + 1);
        if (k % 2 == 1) acc = acc - t;
        else acc = acc + t;
      end
    end
    return 64'(acc >> 8);
  endfunction

  function automatic logic [63:0] pi_scaled(input int frac);
    return (PI_Q61 + (64'd1 << (60 - frac))) >> (61 - frac);
  endfunction

  function automatic logic [63:0] half_pi_scaled(input int frac);
    return (PI_Q61 + (64'd1 << (61 - frac))) >> (62 - frac);
  endfunction

  function automatic logic [63:0] k_scaled(input int frac);
    if (frac >= 30) return K_Q30 << (frac - 30);
    return (K_Q30 + (64'd1 << (29 - frac))) >> (30 - frac);
  endfunction

endpackage

// File: rtl/cordic_iter_param_atan_rom.sv
// Combinational arctangent table indexed by iteration number.
// Entries are atan(2^-i) at the datapath's fractional scaling.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 29,
  parameter int ITER  = 16,
  parameter int CW    = 4
) (
  input  logic [CW-1:0]    idx,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] tab [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_tab
    localparam logic [63:0] A = atan_q61(g) >> (ATAN_FB - FRAC);
    assign tab[g] = A[WIDTH-1:0];
  end

  always_comb begin
    value = '0;
    for (int g = 0; g < ITER; g++)
      if (idx == CW'(g)) value = tab[g];
  end

endmodule

// File: rtl/cordic_iter_param.sv
// Iterative CORDIC core, one micro-rotation per clock.
// Rotation gives cos/sin, vectoring gives magnitude and atan2.
module cordic_iter_param
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 29,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             busy
);

  localparam int DW = WIDTH + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [WIDTH-1:0] PI_W  = WIDTH'(pi_scaled(FRAC));
  localparam logic signed [WIDTH-1:0] HPI_W = WIDTH'(half_pi_scaled(FRAC));
  localparam logic signed [DW-1:0]    K_D   = DW'(k_scaled(FRAC));
  localparam logic signed [DW-1:0] DMAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {3'b111, {(WIDTH-1){1'b0}}};

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic signed [DW-1:0]    x, y;
  logic signed [WIDTH-1:0] z;
  logic                    mode, neg, zero;

  logic signed [DW-1:0]    x_sh, y_sh, x_nx, y_nx, x_res, y_res;
  logic signed [DW-1:0]    x_in, y_in, xe, ye;
  logic signed [WIDTH-1:0] z_nx, z_in, th, a;
  logic [WIDTH-1:0]        rom_out;
  logic                    d_pos, neg_in, zero_in, accept, last;

  cordic_atan_rom #(
    .WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER), .CW(CW)
  ) u_rom (
    .idx   (cnt),
    .value (rom_out)
  );

  assign a        = rom_out;
  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state == S_RUN);
  assign last     = (cnt == CW'(ITER - 1));

  assign x_sh  = x >>> cnt;
  assign y_sh  = y >>> cnt;
  assign d_pos = (mode == MODE_VEC) ? y[DW-1] : ~z[WIDTH-1];
  assign x_nx  = d_pos ? x - y_sh : x + y_sh;
  assign y_nx  = d_pos ? y + x_sh : y - x_sh;
  assign z_nx  = d_pos ? z - a : z + a;
  assign x_res = neg ? -x_nx : x_nx;
  assign y_res = neg ? -y_nx : y_nx;

  assign th = in_z;
  assign xe = {{2{in_x[WIDTH-1]}}, in_x};
  assign ye = {{2{in_y[WIDTH-1]}}, in_y};

  // Fold operands into the convergence range of the iterations
  always_comb begin
    x_in    = K_D;
    y_in    = '0;
    z_in    = th;
    neg_in  = 1'b0;
    zero_in = 1'b0;
    if (in_mode == MODE_VEC) begin
      zero_in = (in_x == '0) && (in_y == '0);
      if (in_x[WIDTH-1]) begin
        x_in = -xe;
        y_in = -ye;
        z_in = in_y[WIDTH-1] ? -PI_W : PI_W;
      end else begin
        x_in = xe;
        y_in = ye;
        z_in = '0;
      end
    end else if (th > HPI_W) begin
      z_in   = th - PI_W;
      neg_in = 1'b1;
    end else if (th < -HPI_W) begin
      z_in   = th + PI_W;
      neg_in = 1'b1;
    end
  end

  function automatic logic [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    if (v > DMAX) return {1'b0, {(WIDTH-1){1'b1}}};
    if (v < DMIN) return {1'b1, {(WIDTH-1){1'b0}}};
    return v[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      mode      <= 1'b0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            x         <= x_in;
            y         <= y_in;
            z         <= z_in;
            mode      <= in_mode;
            neg       <= neg_in;
            zero      <= zero_in;
            cnt       <= '0;
            out_valid <= 1'b0;
            state     <= S_RUN;
          end else if (state == S_DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_RUN: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          if (last) begin
            out_x     <= zero ? '0 : sat(x_res);
            out_y     <= zero ? '0 : sat(y_res);
            out_z     <= zero ? '0 : z_nx;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_param.sv
// Directed and randomised checks of cordic_iter_param
// against constants and a real-valued trig model.
module tb_cordic_iter_param;

  localparam int W = 32;
  localparam real ONE  = 536870912.0;
  localparam real PI_R = 3.14159265358979324;
  localparam real AN   = 1.6467602581210656;
  localparam real TOL  = 32768.0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic [W-1:0] in_z = '0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out_x, out_y, out_z;

  int checks = 0;
  int passed = 0;

  cordic_iter_param #(.WIDTH(32), .FRAC(29), .ITER(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic longint sv(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string tag, input longint got, input longint want);
    checks++;
    assert (got === want) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic near(input string tag, input longint got, input real want,
                      input real tol, input bit wrap);
    real d;
    bit ok;
    d = real'(got) - want;
    if (wrap && d > PI_R * ONE) d = d - 2.0 * PI_R * ONE;
    if (wrap && d < -PI_R * ONE) d = d + 2.0 * PI_R * ONE;
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0.1f", tag, got, want);
    end
  endtask

  task automatic start(input logic m, input longint x, input longint y,
                       input longint z);
    @(negedge clk);
    chk("in_ready_idle", longint'(in_ready), 1);
    in_mode  = m;
    in_x     = x[W-1:0];
    in_y     = y[W-1:0];
    in_z     = z[W-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 32'h5A5A_1234;
    in_y     = 32'hA5A5_4321;
    in_z     = 32'h7654_3210;
    in_mode  = ~m;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", longint'(out_valid), 0);
  endtask

  task automatic rot_op(input string tag, input longint th);
    int lat;
    start(1'b0, 0, 0, th);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 16);
    near({tag, "_cos"}, sv(out_x), $cos(real'(th) / ONE) * ONE, TOL, 1'b0);
    near({tag, "_sin"}, sv(out_y), $sin(real'(th) / ONE) * ONE, TOL, 1'b0);
  endtask

  initial begin
    int lat;
    longint ox, oy, oz, t, vx, vy;
    bit ok;
    logic m;

    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_x", sv(out_x), 0);
    chk("rst_out_z", sv(out_z), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    start(1'b0, 0, 0, 0);
    chk("busy_run", longint'(busy), 1);
    wait_done(lat);
    chk("rot0_lat", lat, 16);
    near("rot0_cos", sv(out_x), ONE, TOL, 1'b0);
    near("rot0_sin", sv(out_y), 0.0, TOL, 1'b0);
    consume();

    start(1'b0, 0, 0, 843314857);
    wait_done(lat);
    near("rot90_cos", sv(out_x), 0.0, TOL, 1'b0);
    near("rot90_sin", sv(out_y), ONE, TOL, 1'b0);
    consume();

    start(1'b0, 0, 0, -1686629713);
    wait_done(lat);
    near("rotm180_cos", sv(out_x), -ONE, TOL, 1'b0);
    near("rotm180_sin", sv(out_y), 0.0, TOL, 1'b0);
    consume();

    start(1'b1, -536870912, 0, 0);
    wait_done(lat);
    chk("vec_lat", lat, 16);
    near("vec_neg_z", sv(out_z), 1686629713.0, TOL, 1'b0);
    near("vec_neg_mag", sv(out_x), 884097682.0, TOL, 1'b0);
    near("vec_neg_y", sv(out_y), 0.0, 4.0 * TOL, 1'b0);
    consume();

    start(1'b1, 0, 0, 0);
    wait_done(lat);
    chk("vec0_x", sv(out_x), 0);
    chk("vec0_y", sv(out_y), 0);
    chk("vec0_z", sv(out_z), 0);
    consume();

    // backpressure: result must hold while the consumer stalls
    start(1'b0, 0, 0, 268435456);
    wait_done(lat);
    near("bp_cos", sv(out_x), $cos(0.5) * ONE, TOL, 1'b0);
    near("bp_sin", sv(out_y), $sin(0.5) * ONE, TOL, 1'b0);
    ox = sv(out_x);
    oy = sv(out_y);
    oz = sv(out_z);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      ok = out_valid && !in_ready && !busy &&
           sv(out_x) == ox && sv(out_y) == oy && sv(out_z) == oz;
      chk("bp_hold", longint'(ok), 1);
    end

    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_z      = -32'sd268435456;
    #1;
    chk("b2b_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_z      = 32'h3000_0000;
    chk("b2b_busy", longint'(busy), 1);
    chk("b2b_valid", longint'(out_valid), 0);
    wait_done(lat);
    chk("b2b_lat", lat, 16);
    near("b2b_cos", sv(out_x), $cos(-0.5) * ONE, TOL, 1'b0);
    near("b2b_sin", sv(out_y), $sin(-0.5) * ONE, TOL, 1'b0);
    consume();

    // asynchronous reset in the middle of an operation
    start(1'b0, 0, 0, 32'h1000_0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out_x", sv(out_x), 0);
    chk("arst_out_y", sv(out_y), 0);
    chk("arst_out_z", sv(out_z), 0);
    chk("arst_valid", longint'(out_valid), 0);
    chk("arst_in_ready", longint'(in_ready), 1);
    chk("arst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ok = 1'b1;
    end
    chk("arst_no_stale", longint'(ok), 0);
    rot_op("post_rst", 134217728);
    consume();

    for (int n = 0; n < 1000; n++) begin
      m = 1'($urandom_range(1, 0));
      if (m == 1'b0) begin
        t = longint'($urandom_range(32'd3373259426, 0)) - 1686629713;
        start(1'b0, 0, 0, t);
        wait_done(lat);
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1;
        chk("rnd_rot_valid", longint'(out_valid), 1);
        near("rnd_cos", sv(out_x), $cos(real'(t) / ONE) * ONE, TOL, 1'b0);
        near("rnd_sin", sv(out_y), $sin(real'(t) / ONE) * ONE, TOL, 1'b0);
      end else begin
        vx = longint'($urandom_range(32'd1073741824, 0)) - 536870912;
        vy = longint'($urandom_range(32'd1073741824, 0)) - 536870912;
        if ((vx < 0 ? -vx : vx) + (vy < 0 ? -vy : vy) < 134217728)
          vx = 268435456;
        start(1'b1, vx, vy, 0);
        wait_done(lat);
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1;
        chk("rnd_vec_valid", longint'(out_valid), 1);
        near("rnd_mag", sv(out_x),
             AN * $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy)),
             2.0 * TOL, 1'b0);
        near("rnd_atan", sv(out_z),
             $atan2(real'(vy), real'(vx)) * ONE, TOL, 1'b1);
        near("rnd_resid", sv(out_y), 0.0, 4.0 * TOL, 1'b0);
      end
      consume();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
